imem_loader: RTL and testbench

- Serial program loader: receives a byte stream, assembles big-endian 32-bit MIPS instruction words and writes them into instruction memory.
- Holds the CPU (datapath and controller) in reset while loading.
- It is the writer end of the instruction-memory interface that the fetch/decode path reads.
- Sits between the host/UART byte source and the imem write port.

---
 rtl/imem_loader_pkg.sv | 5 +
 rtl/imem_loader_byte_packer.sv | 26 ++
 rtl/imem_loader.sv | 86 ++++++++
 tb/tb_imem_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and word geometry for the instruction-memory loader.
package imem_loader_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CSUM, DONE} state_t;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles big-endian words from a byte stream and flags the final byte of a word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        last
);
    logic [1:0] cnt;
    assign last = cnt == 2'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift) begin
            cnt  <= cnt + 2'd1;
            word <= {word[23:0], in_byte};
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: serial program loader that writes instruction words into imem while holding the CPU in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_wa,
    output logic [DATA_W-1:0] imem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;
    state_t            state, state_n;
    logic [7:0]        n, csum;
    logic [ADDR_W:0]   wcnt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              last, xfer, hdr_bad, last_word;
    assign xfer      = in_valid & in_ready;
    assign hdr_bad   = in_byte == 8'd0 || int'(in_byte) > DEPTH;
    assign last_word = int'(wcnt) + 1 == int'(n);
    byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state == IDLE && start),
        .shift   (state == DATA && xfer),
        .in_byte (in_byte),
        .word    (word),
        .last    (last)
    );
    always_comb begin
        state_n  = state;
        in_ready = state == HDR || state == DATA || state == CSUM;
        imem_we  = state == WRITE;
        cpu_hold = state != IDLE;
        done     = state == DONE;
        imem_wa  = addr;
        imem_wd  = word;
        case (state)
            IDLE:    if (start) state_n = HDR;
            HDR:     if (xfer) state_n = hdr_bad ? IDLE : DATA;
            DATA:    if (xfer && last) state_n = WRITE;
            WRITE:   state_n = last_word ? CSUM : DATA;
            CSUM:    if (xfer) state_n = in_byte == csum ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            n     <= '0;
            csum  <= '0;
            wcnt  <= '0;
            addr  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                err  <= 1'b0;
                addr <= '0;
                csum <= '0;
                wcnt <= '0;
            end
            if (state == HDR && xfer) begin
                if (hdr_bad) err <= 1'b1;
                else n <= in_byte;
            end
            if (state == DATA && xfer) csum <= csum ^ in_byte;
            // address wraps naturally once all 2^ADDR_W words are written
            if (state == WRITE) begin
                addr <= addr + 1'b1;
                wcnt <= wcnt + 1'b1;
            end
            if (state == CSUM && xfer && in_byte != csum) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized load sessions checked against a queue-based model of the expected memory writes.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;
    logic              clk = 0, reset = 0, start = 0, in_valid = 0;
    logic [7:0]        in_byte = 0;
    logic              in_ready, imem_we, cpu_hold, done, err;
    logic [ADDR_W-1:0] imem_wa;
    logic [31:0]       imem_wd;
    int vectors = 0, miscompares = 0, done_cnt = 0;
    logic [ADDR_W+31:0] got_q[$], exp_q[$];
    logic [31:0] words[DEPTH];

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    always @(negedge clk) begin
        if (imem_we) got_q.push_back({imem_wa, imem_wd});
        if (done) begin
            done_cnt++;
            chk("done_hold", cpu_hold, 1);
            chk("done_err", err, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int stall);
        int t = 0;
        @(negedge clk);
        if (stall == 1) @(negedge clk);
        else if (stall == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1;
        in_byte  = b;
        while (!in_ready && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (t == 16) chk("rdy_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic session(input int n, input bit good_cs, input logic [7:0] bad_cs,
                           input int stall, input bit bad_start);
        bit nv = n >= 1 && n <= DEPTH;
        bit exp_err;
        logic [7:0] cs = 0;
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        if (nv) for (int i = 0; i < n; i++) begin
            exp_q.push_back({ADDR_W'(i), words[i]});
            cs ^= xsum(words[i]);
        end
        exp_err = !nv || !(good_cs || bad_cs == cs);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk("hold_after_start", cpu_hold, 1);
        send_byte(8'(n), stall);
        if (nv) begin
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++) begin
                    send_byte(words[i][31-8*b -: 8], stall);
                    if (bad_start && i == 0 && b == 1) begin
                        @(negedge clk) start = 1;
                        @(negedge clk) start = 0;
                        chk("hold_bad_start", cpu_hold, 1);
                    end
                end
            send_byte(good_cs ? cs : bad_cs, stall);
        end
        repeat (3) @(negedge clk);
        chk("n_writes", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("write", got_q[i], exp_q[i]);
        chk("done_cnt", done_cnt, exp_err ? 0 : 1);
        chk("err", err, exp_err);
        chk("hold_end", cpu_hold, 0);
        chk("addr_end", imem_wa, ADDR_W'(nv ? n : 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #12;
        chk("reset_outs", {in_ready, imem_we, cpu_hold, done, err, imem_wa, imem_wd}, 0);
        @(negedge clk) reset = 1;
        words[0] = 32'h20080005;
        words[1] = 32'h01095020;
        session(2, 1, 0, 0, 0);
        session(0, 1, 0, 0, 0);
        session(8'h41, 1, 0, 0, 0);
        words[0] = 32'hAC0A0004;
        session(1, 0, 8'h00, 0, 0);
        words[0] = 32'h20080005;
        words[1] = 32'h01095020;
        session(2, 1, 0, 1, 1);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        send_byte(8'd1, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(negedge clk) reset = 0;
        #1 chk("midreset_outs", {in_ready, imem_we, cpu_hold, done, err, imem_wa, imem_wd}, 0);
        @(negedge clk) reset = 1;
        words[0] = 32'hDEADBEEF;
        session(1, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            int n = ($urandom_range(0, 4) == 0) ? $urandom_range(65, 255) : $urandom_range(1, 6);
            for (int i = 0; i < 6; i++) words[i] = $urandom;
            session(n, $urandom_range(0, 3) != 0, 8'($urandom), 2, $urandom_range(0, 1));
        end
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        session(DEPTH, 1, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
